id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the MIPS pipeline: registers the EX/MEM/WB control bundles from the control unit together with the decoded operands, and owns the decode-stage stall logic. It inserts bubbles for load-use hazards and branch/jump flushes. It holds a MULTU in EX for a fixed number of cycles, freezing PC and IF/ID for that time.

## Interface
- DATA_W, 32, operand/immediate/PC width
- MULTU_CYCLES, 32, total cycles a MULTU occupies ID/EX (>=1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- EX_in  in  4  {RegDst, ALUOp[1:0], ALUSrc} from control unit
- MEM_in  in  3  {MemRead, MemWrite, Branch}
- WB_in  in  2  {RegWrite, MemtoReg}
- Funct_in  in  6  instruction funct field
- RD1_in, RD2_in  in  DATA_W  register file read data
- Imm_in  in  DATA_W  extended immediate
- PCplus4_in  in  DATA_W  PC+4 of decoded instruction
- Rs_in, Rt_in, Rd_in  in  5  register specifiers of decoded instruction
- Flush  in  1  taken branch/jump; kill ID/EX contents
- EX_out, MEM_out, WB_out  out  4/3/2  registered control bundles
- Funct_out  out  6; RD1_out, RD2_out, Imm_out, PCplus4_out  out  DATA_W; Rs_out, Rt_out, Rd_out  out  5  registered data fields
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register update enable
- MultBusy  out  1  MULTU holding ID/EX

## Operation
- Bubble: EX/MEM/WB/Funct fields loaded with 0. Data fields load their inputs (don't-care contents).
- is_multu_in: EX_in[2:1]==2'b10 and Funct_in==6'd25.
- load_use (combinational): MEM_out[2]==1 and Rt_out!=0 and (Rt_out==Rs_in or Rt_out==Rt_in).
- FSM states: IDLE, MUL_BUSY. Down-counter cnt, width clog2(MULTU_CYCLES)+1.
- Next-state priority per edge: reset > Flush > MUL_BUSY hold > load_use bubble > normal capture.
  - Flush: load bubble, cnt=0, go IDLE. Aborts an in-flight MULTU.
  - MUL_BUSY: hold all ID/EX fields; cnt-=1; when cnt becomes 0, go IDLE.
  - IDLE with load_use: load bubble.
  - IDLE normal: capture all inputs. If is_multu_in and MULTU_CYCLES>1: cnt=MULTU_CYCLES-1, go MUL_BUSY.
- MultBusy = (state==MUL_BUSY).
- PCWrite = IFIDWrite = Flush | ~(MultBusy | (load_use & state==IDLE)).
- Control inputs are not sanitised. X on EX_in/MEM_in/WB_in propagates.

## Timing
- Reset (rst_n low at edge): all registered outputs 0, state IDLE, cnt 0. Hence PCWrite=IFIDWrite=1, MultBusy=0 from the first cycle after reset. rst_n is ignored between edges.
- Normal latency: inputs at edge N appear on outputs after edge N, one cycle.
- Load-use: stall visible in the same cycle the dependent instruction is in ID. One bubble enters at the next edge. The dependent instruction re-presents (IF/ID held) and is captured one cycle later. Total penalty: 1 cycle.
- MULTU captured at edge N: outputs hold it from N through edge N+MULTU_CYCLES-1. The next instruction is captured at edge N+MULTU_CYCLES. PCWrite=IFIDWrite=0 for MULTU_CYCLES-1 cycles.
- MULTU_CYCLES=1: no hold, MultBusy never asserts.
- Flush and load_use in the same cycle: flush wins; bubble loaded, PCWrite=IFIDWrite=1.
- Flush in the final MUL_BUSY cycle: bubble, IDLE.
- Reset mid-MULTU: immediate IDLE, cnt 0.
- A MULTU behind a lw with a load-use dependency: bubble first. The MULTU is captured next cycle, then the hold starts.

## Test plan
- Reset: hold rst_n=0 for 2 edges with nonzero inputs -> all outputs 0, PCWrite=IFIDWrite=1, MultBusy=0. Release -> next edge captures inputs (EX_in=4'b1100 -> EX_out=4'b1100).
- Load-use: lw captured (MEM_out=3'b100, Rt_out=8). Next ID has Rs_in=8 -> PCWrite=IFIDWrite=0 that cycle; next edge EX_out=MEM_out=WB_out=0. Following cycle stall deasserts and the instruction is captured. Repeat with Rt_out=0 -> no stall.
- MULTU, MULTU_CYCLES=4: capture EX_in=4'b1100, Funct_in=25 -> MultBusy=1 for 3 cycles; outputs unchanged for 4 cycles; PCWrite low for 3 cycles; new instruction captured at the 4th edge.
- Flush during MUL_BUSY (second busy cycle) -> next edge bubble, MultBusy=0, PCWrite=1.
- Simultaneous Flush and load_use -> bubble, PCWrite=IFIDWrite=1. Then a sw (EX_in=4'b0001, MEM_in=3'b010) flows through unstalled with 1-cycle latency.
- rst_n low during MUL_BUSY -> next edge outputs 0, MultBusy=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode-stage hazard control.
// Inserts bubbles on load-use hazards and branch/jump flushes, and holds a
// MULTU in EX for MULTU_CYCLES cycles while freezing PC and IF/ID.
module id_ex_stage #(
  parameter int DATA_W       = 32,
  parameter int MULTU_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        EX_in,
  input  logic [2:0]        MEM_in,
  input  logic [1:0]        WB_in,
  input  logic [5:0]        Funct_in,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] Imm_in,
  input  logic [DATA_W-1:0] PCplus4_in,
  input  logic [4:0]        Rs_in,
  input  logic [4:0]        Rt_in,
  input  logic [4:0]        Rd_in,
  input  logic              Flush,
  output logic [3:0]        EX_out,
  output logic [2:0]        MEM_out,
  output logic [1:0]        WB_out,
  output logic [5:0]        Funct_out,
  output logic [DATA_W-1:0] RD1_out,
  output logic [DATA_W-1:0] RD2_out,
  output logic [DATA_W-1:0] Imm_out,
  output logic [DATA_W-1:0] PCplus4_out,
  output logic [4:0]        Rs_out,
  output logic [4:0]        Rt_out,
  output logic [4:0]        Rd_out,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              MultBusy
);

  localparam int              CNT_W    = $clog2(MULTU_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTU_CYCLES - 1);
  // A single-cycle MULTU needs no hold at all.
  localparam logic            HOLD_EN  = (MULTU_CYCLES > 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         ex_q, ex_d;
  logic [2:0]         mem_q, mem_d;
  logic [1:0]         wb_q, wb_d;
  logic [5:0]         funct_q, funct_d;
  logic [DATA_W-1:0]  rd1_q, rd1_d;
  logic [DATA_W-1:0]  rd2_q, rd2_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0]  pc4_q, pc4_d;
  logic [4:0]         rs_q, rs_d;
  logic [4:0]         rt_q, rt_d;
  logic [4:0]         rd_q, rd_d;

  logic is_multu_in;
  logic load_use;
  logic mult_busy;

  assign is_multu_in = (EX_in[2:1] == 2'b10) && (Funct_in == 6'd25);
  // The load in EX (MemRead) writes Rt; a reader of that register in ID must wait.
  assign load_use    = mem_q[2] && (rt_q != 5'd0) && ((rt_q == Rs_in) || (rt_q == Rt_in));
  assign mult_busy   = (state_q == MUL_BUSY);

  // Next-state selection: flush beats the MULTU hold, which beats the load-use bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    funct_d = funct_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;

    if (Flush || (!mult_busy && load_use)) begin
      // Bubble: control zeroed, data fields simply follow the inputs.
      ex_d    = 4'd0;
      mem_d   = 3'd0;
      wb_d    = 2'd0;
      funct_d = 6'd0;
      rd1_d   = RD1_in;
      rd2_d   = RD2_in;
      imm_d   = Imm_in;
      pc4_d   = PCplus4_in;
      rs_d    = Rs_in;
      rt_d    = Rt_in;
      rd_d    = Rd_in;
      if (Flush) begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else if (mult_busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
      end
    end else begin
      ex_d    = EX_in;
      mem_d   = MEM_in;
      wb_d    = WB_in;
      funct_d = Funct_in;
      rd1_d   = RD1_in;
      rd2_d   = RD2_in;
      imm_d   = Imm_in;
      pc4_d   = PCplus4_in;
      rs_d    = Rs_in;
      rt_d    = Rt_in;
      rd_d    = Rd_in;
      if (is_multu_in && HOLD_EN) begin
        cnt_d   = CNT_LOAD;
        state_d = MUL_BUSY;
      end
    end
  end

  // Pipeline register and FSM state, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      funct_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      funct_q <= funct_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

  assign EX_out      = ex_q;
  assign MEM_out     = mem_q;
  assign WB_out      = wb_q;
  assign Funct_out   = funct_q;
  assign RD1_out     = rd1_q;
  assign RD2_out     = rd2_q;
  assign Imm_out     = imm_q;
  assign PCplus4_out = pc4_q;
  assign Rs_out      = rs_q;
  assign Rt_out      = rt_q;
  assign Rd_out      = rd_q;

  // A flush redirects fetch, so it always re-enables PC and IF/ID.
  assign MultBusy  = mult_busy;
  assign PCWrite   = Flush | ~(mult_busy | (load_use & (state_q == IDLE)));
  assign IFIDWrite = PCWrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver issues directed then random
// instructions and queues the expected view of each cycle; a monitor pops
// and compares on the falling edge.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int MC = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    EX_in;
  logic [2:0]    MEM_in;
  logic [1:0]    WB_in;
  logic [5:0]    Funct_in;
  logic [DW-1:0] RD1_in, RD2_in, Imm_in, PCplus4_in;
  logic [4:0]    Rs_in, Rt_in, Rd_in;
  logic          Flush;
  logic [3:0]    EX_out;
  logic [2:0]    MEM_out;
  logic [1:0]    WB_out;
  logic [5:0]    Funct_out;
  logic [DW-1:0] RD1_out, RD2_out, Imm_out, PCplus4_out;
  logic [4:0]    Rs_out, Rt_out, Rd_out;
  logic          PCWrite, IFIDWrite, MultBusy;

  id_ex_stage #(.DATA_W(DW), .MULTU_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_in(EX_in), .MEM_in(MEM_in), .WB_in(WB_in), .Funct_in(Funct_in),
    .RD1_in(RD1_in), .RD2_in(RD2_in), .Imm_in(Imm_in), .PCplus4_in(PCplus4_in),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .Flush(Flush),
    .EX_out(EX_out), .MEM_out(MEM_out), .WB_out(WB_out), .Funct_out(Funct_out),
    .RD1_out(RD1_out), .RD2_out(RD2_out), .Imm_out(Imm_out), .PCplus4_out(PCplus4_out),
    .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .MultBusy(MultBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          flush;
    logic [3:0]    ex;
    logic [2:0]    mem;
    logic [1:0]    wb;
    logic [5:0]    funct;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [4:0]    rs, rt, rd;
  } instr_t;

  typedef struct {
    logic [3:0]    ex;
    logic [2:0]    mem;
    logic [1:0]    wb;
    logic [5:0]    funct;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [4:0]    rs, rt, rd;
    bit            data_ok;   // data fields are meaningful (not a bubble)
    bit            pcw;
    bit            busy;
  } view_t;

  view_t  exp_q[$];
  view_t  mdl;          // what the ID/EX register should hold now
  int     hold_left;    // remaining cycles the MULTU keeps ID/EX frozen
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  bit     done   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  function automatic instr_t base();
    instr_t x;
    x.rst_n = 1'b1; x.flush = 1'b0;
    x.ex = 4'd0; x.mem = 3'd0; x.wb = 2'd0; x.funct = 6'd0;
    x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom; x.pc4 = $urandom;
    x.rs = 5'd0; x.rt = 5'd0; x.rd = 5'd0;
    return x;
  endfunction

  function automatic instr_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    instr_t x = base();
    x.ex = 4'b1100; x.wb = 2'b10; x.funct = 6'd32;
    x.rs = rs; x.rt = rt; x.rd = rd;
    return x;
  endfunction

  function automatic instr_t lw(input logic [4:0] rs, input logic [4:0] rt);
    instr_t x = base();
    x.ex = 4'b0001; x.mem = 3'b100; x.wb = 2'b11;
    x.rs = rs; x.rt = rt;
    return x;
  endfunction

  function automatic instr_t multu(input logic [4:0] rs, input logic [4:0] rt);
    instr_t x = base();
    x.ex = 4'b1100; x.funct = 6'd25;
    x.rs = rs; x.rt = rt;
    return x;
  endfunction

  // Contents of ID/EX if the instruction is taken as-is (bubble zeroes control).
  function automatic view_t load_view(input instr_t x, input bit bubble);
    view_t v;
    v.ex    = bubble ? 4'd0 : x.ex;
    v.mem   = bubble ? 3'd0 : x.mem;
    v.wb    = bubble ? 2'd0 : x.wb;
    v.funct = bubble ? 6'd0 : x.funct;
    v.rd1 = x.rd1; v.rd2 = x.rd2; v.imm = x.imm; v.pc4 = x.pc4;
    v.rs = x.rs; v.rt = x.rt; v.rd = x.rd;
    v.data_ok = !bubble;
    v.pcw = 1'b1; v.busy = 1'b0;
    return v;
  endfunction

  // Present one instruction for one cycle, record what the cycle should look
  // like, then advance the reference model across the clock edge.
  task automatic drive(input instr_t x);
    view_t e;
    bit    hazard;
    rst_n = x.rst_n; Flush = x.flush;
    EX_in = x.ex; MEM_in = x.mem; WB_in = x.wb; Funct_in = x.funct;
    RD1_in = x.rd1; RD2_in = x.rd2; Imm_in = x.imm; PCplus4_in = x.pc4;
    Rs_in = x.rs; Rt_in = x.rt; Rd_in = x.rd;

    hazard = mdl.mem[2] && (mdl.rt != 5'd0) && (mdl.rt == x.rs || mdl.rt == x.rt);
    e      = mdl;
    e.busy = (hold_left > 0);
    e.pcw  = x.flush || !(hold_left > 0 || hazard);
    exp_q.push_back(e);

    if (!x.rst_n) begin
      mdl = '{default: 0};
      mdl.data_ok = 1'b1;
      hold_left = 0;
    end else if (x.flush) begin
      mdl = load_view(x, 1'b1);
      hold_left = 0;
    end else if (hold_left > 0) begin
      hold_left = hold_left - 1;
    end else if (hazard) begin
      mdl = load_view(x, 1'b1);
    end else begin
      mdl = load_view(x, 1'b0);
      if (x.ex[2:1] == 2'b10 && x.funct == 6'd25)
        hold_left = MC - 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge the DUT presents one cycle's view.
  view_t m;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      cyc++;
      $display("cyc %0d ex=%h mem=%h wb=%h fn=%0d rt=%0d pcw=%b busy=%b",
               cyc, EX_out, MEM_out, WB_out, Funct_out, Rt_out, PCWrite, MultBusy);
      chk("EX_out",    DW'(EX_out),    DW'(m.ex));
      chk("MEM_out",   DW'(MEM_out),   DW'(m.mem));
      chk("WB_out",    DW'(WB_out),    DW'(m.wb));
      chk("Funct_out", DW'(Funct_out), DW'(m.funct));
      chk("PCWrite",   DW'(PCWrite),   DW'(m.pcw));
      chk("IFIDWrite", DW'(IFIDWrite), DW'(m.pcw));
      chk("MultBusy",  DW'(MultBusy),  DW'(m.busy));
      if (m.data_ok) begin
        chk("RD1_out", RD1_out, m.rd1);
        chk("RD2_out", RD2_out, m.rd2);
        chk("Imm_out", Imm_out, m.imm);
        chk("PC4_out", PCplus4_out, m.pc4);
        chk("Rs_out",  DW'(Rs_out), DW'(m.rs));
        chk("Rt_out",  DW'(Rt_out), DW'(m.rt));
        chk("Rd_out",  DW'(Rd_out), DW'(m.rd));
      end
    end
  end

  instr_t x;
  initial begin
    // Edge at t=5 sees reset with all inputs zero.
    rst_n = 1'b0; Flush = 1'b0;
    EX_in = '0; MEM_in = '0; WB_in = '0; Funct_in = '0;
    RD1_in = '0; RD2_in = '0; Imm_in = '0; PCplus4_in = '0;
    Rs_in = '0; Rt_in = '0; Rd_in = '0;
    mdl = '{default: 0};
    mdl.data_ok = 1'b1;
    hold_left = 0;
    @(posedge clk);
    #1;

    // Reset held for two edges with busy-looking inputs.
    x = multu(5'd7, 5'd9); x.mem = 3'b111; x.wb = 2'b11; x.rst_n = 1'b0;
    drive(x); drive(x);
    drive(alu(5'd1, 5'd2, 5'd3));

    // Load-use: one bubble, then the dependent add is captured.
    drive(lw(5'd1, 5'd8));
    x = alu(5'd8, 5'd9, 5'd10);
    drive(x); drive(x);
    // lw to $0 never stalls.
    drive(lw(5'd1, 5'd0));
    drive(alu(5'd0, 5'd0, 5'd11));

    // MULTU with a full hold, followed by an add waiting in IF/ID.
    drive(multu(5'd4, 5'd5));
    x = alu(5'd6, 5'd7, 5'd12);
    for (int i = 0; i < MC + 1; i++) drive(x);

    // Flush on the second busy cycle aborts the hold.
    drive(multu(5'd4, 5'd5));
    drive(alu(5'd1, 5'd1, 5'd1));
    x = alu(5'd2, 5'd2, 5'd2); x.flush = 1'b1;
    drive(x);
    drive(alu(5'd3, 5'd3, 5'd3));

    // Flush together with a load-use hazard, then a store flows through.
    drive(lw(5'd1, 5'd5));
    x = alu(5'd5, 5'd1, 5'd2); x.flush = 1'b1;
    drive(x);
    x = base(); x.ex = 4'b0001; x.mem = 3'b010; x.rs = 5'd3; x.rt = 5'd4;
    drive(x);
    drive(alu(5'd4, 5'd4, 5'd4));

    // MULTU dependent on a load: bubble first, then capture and hold.
    drive(lw(5'd1, 5'd6));
    x = multu(5'd6, 5'd2);
    drive(x); drive(x);
    x = alu(5'd1, 5'd2, 5'd3);
    for (int i = 0; i < MC; i++) drive(x);

    // Reset in the middle of a MULTU hold.
    drive(multu(5'd4, 5'd5));
    drive(alu(5'd1, 5'd1, 5'd1));
    x = alu(5'd1, 5'd1, 5'd1); x.rst_n = 1'b0;
    drive(x);
    drive(alu(5'd2, 5'd3, 5'd4));

    // Random traffic over a small register set to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      x = base();
      x.ex    = ($urandom_range(0, 3) == 0) ? 4'b1100 : 4'($urandom);
      x.mem   = 3'($urandom);
      x.wb    = 2'($urandom);
      x.funct = ($urandom_range(0, 2) == 0) ? 6'd25 : 6'($urandom);
      x.rs    = 5'($urandom_range(0, 3));
      x.rt    = 5'($urandom_range(0, 3));
      x.rd    = 5'($urandom);
      x.flush = ($urandom_range(0, 11) == 0);
      x.rst_n = ($urandom_range(0, 49) != 0);
      drive(x);
    end

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
